uart_boot_loader: RTL

- Parametrised successor to the fixed two-bank UART programming path around the CPU top.
- Owns start-button debounce, the programming-mode latch and CPU reset generation.
- Contains an 8N1 UART RX/TX, byte-to-word assembly, and sequential word writes into NUM_BANKS memories (bank 0 = instruction ROM, bank 1 = data RAM, more for MMIO buffers).
- Sits between the board pins (start_pg, rx, tx) and the memory write ports.
- The CPU is held in reset while a load session is active.

---
 rtl/uart_boot_pkg.sv | 25 ++
 rtl/uart_rx_tx.sv | 173 +++++++++++++++++
 rtl/uart_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_pkg;

  // Loader session states
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT_LO,
    CNT_HI,
    DATA,
    ACK,
    NAK,
    END
  } boot_state_t;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [7:0] END_HDR  = 8'hFF;

  // Integer clocks per UART bit (truncating division)
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_tx.sv
// 8N1 UART receiver and transmitter sharing one bit period.
// The RX input is expected to be synchronised already.
module uart_rx_tx
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       tx_o
);

  localparam int CPB    = (CLKS_PER_BIT < 2) ? 2 : CLKS_PER_BIT;
  localparam int HALF   = CPB / 2;
  localparam int CNT_W  = $clog2(CPB);

  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_prev_q;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;

  // RX and TX state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_prev_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_prev_q  <= rx_i;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // RX: falling-edge start, half-bit start check, mid-bit sampling, stop check
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_i) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          if (rx_i) begin
            rx_state_d = RX_IDLE;  // glitch, not a real start bit
          end else begin
            rx_state_d = RX_BITS;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_BITS: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_i, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_i;
          rx_ferr_d  = !rx_i;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX: start bit on accept, then 8 data bits LSB first, then stop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_start_i) begin
          tx_state_d = TX_BUSY;
          tx_shift_d = {1'b1, tx_data_i};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_BUSY: begin
        if (tx_cnt_q == FULL_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign rx_data_o  = rx_shift_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_ferr_o  = rx_ferr_q;
  assign tx_busy_o  = (tx_state_q != TX_IDLE);
  assign tx_o       = tx_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: debounced start button opens a session that holds the
// CPU in reset while framed word streams are written into memory banks.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int CLK_FREQ  = 23000000,
  parameter int BAUD      = 115200,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 14,
  parameter int DEB_MS    = 10
) (
  input  logic                 fpga_clk,
  input  logic                 fpga_rst,
  input  logic                 start_pg,
  input  logic                 rx,
  output logic                 tx,
  output logic                 cpu_rst,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [31:0]          wr_data,
  output logic                 load_active,
  output logic                 load_done,
  output logic                 err
);

  localparam int    CPB     = clks_per_bit(CLK_FREQ, BAUD);
  localparam longint DEB_CYC = (longint'(DEB_MS) * longint'(CLK_FREQ)) / 1000;
  localparam int    DEB_N   = (DEB_CYC < 1) ? 1 : int'(DEB_CYC);
  localparam int    DEB_W   = $clog2(DEB_N + 1);
  localparam int    BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // Input synchronisers and debounce
  logic             rx_meta_q, rx_sync_q;
  logic             st_meta_q, st_sync_q;
  logic             deb_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             press_q;

  // UART interface
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  // Session FSM
  boot_state_t          state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [7:0]           cnt_lo_q, cnt_lo_d;
  logic [15:0]          remain_q, remain_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [23:0]          word_q, word_d;
  logic [NUM_BANKS-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;
  logic                 load_active_q, load_active_d;
  logic                 load_done_q, load_done_d;
  logic                 err_q, err_d;
  logic                 cpu_rst_q, cpu_rst_d;

  logic [15:0]          cnt_n;
  logic [NUM_BANKS-1:0] bank_onehot;

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      st_meta_q <= 1'b0;
      st_sync_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      st_meta_q <= start_pg;
      st_sync_q <= st_meta_q;
    end
  end

  // Debounce: accept a new button level only after DEB_N stable cycles;
  // a press is the accepted 0->1 transition
  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (st_sync_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_W'(DEB_N - 1)) begin
        deb_q     <= st_sync_q;
        deb_cnt_q <= '0;
        press_q   <= st_sync_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  uart_rx_tx #(
    .CLKS_PER_BIT(CPB)
  ) u_uart (
    .clk_i      (fpga_clk),
    .rst_ni     (fpga_rst),
    .rx_i       (rx_sync_q),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .tx_data_i  (tx_data),
    .tx_start_i (tx_start),
    .tx_busy_o  (tx_busy),
    .tx_o       (tx)
  );

  assign cnt_n = {rx_data, cnt_lo_q};

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_sel
      assign bank_onehot[gi] = (32'(bank_q) == gi);
    end
  endgenerate

  // Session FSM state and registered outputs
  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      state_q       <= IDLE;
      bank_q        <= '0;
      cnt_lo_q      <= '0;
      remain_q      <= '0;
      addr_q        <= '0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      load_active_q <= 1'b0;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
      cpu_rst_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      cnt_lo_q      <= cnt_lo_d;
      remain_q      <= remain_d;
      addr_q        <= addr_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      load_active_q <= load_active_d;
      load_done_q   <= load_done_d;
      err_q         <= err_d;
      cpu_rst_q     <= cpu_rst_d;
    end
  end

  // Session FSM next state: header, count, data words, replies
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    cnt_lo_d      = cnt_lo_q;
    remain_d      = remain_q;
    addr_d        = addr_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    wr_en_d       = '0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    load_active_d = load_active_q;
    load_done_d   = 1'b0;
    err_d         = err_q;
    tx_start      = 1'b0;
    tx_data       = ACK_BYTE;

    case (state_q)
      IDLE: begin
        if (press_q) begin
          state_d       = HDR;
          load_active_d = 1'b1;
          err_d         = 1'b0;
        end
      end
      HDR: begin
        if (rx_ferr) begin
          err_d   = 1'b1;
          state_d = NAK;
        end else if (rx_valid) begin
          if (32'(rx_data) < 32'(NUM_BANKS)) begin
            bank_d  = rx_data[BANK_W-1:0];
            state_d = CNT_LO;
          end else if (rx_data == END_HDR) begin
            state_d = END;
          end else begin
            err_d   = 1'b1;
            state_d = NAK;
          end
        end
      end
      CNT_LO: begin
        if (rx_ferr) begin
          err_d   = 1'b1;
          state_d = NAK;
        end else if (rx_valid) begin
          cnt_lo_d = rx_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_ferr) begin
          err_d   = 1'b1;
          state_d = NAK;
        end else if (rx_valid) begin
          if (32'(cnt_n) > (32'd1 << ADDR_W)) begin
            err_d   = 1'b1;
            state_d = NAK;
          end else if (cnt_n == 16'd0) begin
            state_d = ACK;
          end else begin
            remain_d   = cnt_n;
            addr_d     = '0;
            byte_idx_d = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (rx_ferr) begin
          err_d   = 1'b1;
          state_d = NAK;
        end else if (rx_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              wr_en_d   = bank_onehot;
              wr_addr_d = addr_q;
              wr_data_d = {rx_data, word_q};
              addr_d    = addr_q + ADDR_W'(1);
              remain_d  = remain_q - 16'd1;
              if (remain_q == 16'd1) begin
                state_d = ACK;
              end
            end
          endcase
        end
      end
      ACK: begin
        tx_data = ACK_BYTE;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = HDR;
        end
      end
      NAK: begin
        tx_data = NAK_BYTE;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = HDR;
        end
      end
      END: begin
        tx_data = ACK_BYTE;
        if (!tx_busy) begin
          tx_start      = 1'b1;
          load_done_d   = 1'b1;
          load_active_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU held in reset for the whole session plus the cycle leaving END
    cpu_rst_d = (state_d != IDLE) || (state_q == END);
  end

  assign cpu_rst     = cpu_rst_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign load_active = load_active_q;
  assign load_done   = load_done_q;
  assign err         = err_q;

endmodule
